// File: rtl/pl_hazard_ctrl.sv
// pl_hazard_ctrl: 5-stage pipeline stall/flush/forward control with dmem wait sequencing
module pl_hazard_ctrl #(
   parameter int MEM_TIMEOUT = 255,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_uses_rs1,
   input  logic             id_uses_rs2,
   input  logic [4:0]       ex_rs1,
   input  logic [4:0]       ex_rs2,
   input  logic [4:0]       ex_rd,
   input  logic             ex_regwrite,
   input  logic [1:0]       ex_resultsrc,
   input  logic             ex_pcsrc,
   input  logic [4:0]       mem_rd,
   input  logic             mem_regwrite,
   input  logic [4:0]       wb_rd,
   input  logic             wb_regwrite,
   input  logic             dmem_req,
   input  logic             dmem_ready,
   output logic             stall_f,
   output logic             stall_d,
   output logic             stall_e,
   output logic             stall_m,
   output logic             flush_d,
   output logic             flush_e,
   output logic             flush_w,
   output logic [1:0]       fwd_a_e,
   output logic [1:0]       fwd_b_e,
   output logic             mem_err,
   output logic [CNT_W-1:0] stall_cycles
);
   localparam int WCW = $clog2(MEM_TIMEOUT + 1);
   localparam logic [WCW-1:0] TIMEOUT = WCW'(MEM_TIMEOUT);
   localparam logic [1:0] S_RUN  = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_ERR  = 2'd2;

   logic [1:0]       r_state;
   logic [WCW-1:0]   r_wait_cnt;
   logic             r_mem_err;
   logic [CNT_W-1:0] r_stall_cycles;
   logic             w_mem_stall;
   logic             w_lu_stall;

   // Hazard detection and strobe generation; memory stall suppresses all flushes so a held branch flushes later
   always_comb begin
      w_mem_stall = (dmem_req & ~dmem_ready) | (r_state == S_ERR);
      w_lu_stall  = ex_regwrite & (ex_resultsrc == 2'b01) & (ex_rd != 5'd0) &
                    ((id_uses_rs1 & (id_rs1 == ex_rd)) | (id_uses_rs2 & (id_rs2 == ex_rd)));
      stall_f     = w_lu_stall | w_mem_stall;
      stall_d     = w_lu_stall | w_mem_stall;
      stall_e     = w_mem_stall;
      stall_m     = w_mem_stall;
      flush_w     = w_mem_stall;
      flush_d     = ex_pcsrc & ~w_mem_stall;
      flush_e     = (w_lu_stall | ex_pcsrc) & ~w_mem_stall;
   end

   // EX operand bypass selects: MEM beats WB, x0 is never forwarded
   always_comb begin
      fwd_a_e = (mem_regwrite && mem_rd != 5'd0 && mem_rd == ex_rs1) ? 2'b10 :
                (wb_regwrite  && wb_rd  != 5'd0 && wb_rd  == ex_rs1) ? 2'b01 : 2'b00;
      fwd_b_e = (mem_regwrite && mem_rd != 5'd0 && mem_rd == ex_rs2) ? 2'b10 :
                (wb_regwrite  && wb_rd  != 5'd0 && wb_rd  == ex_rs2) ? 2'b01 : 2'b00;
   end

   // Data-memory wait sequencer with timeout watchdog; ERROR holds until reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_RUN;
         r_wait_cnt <= '0;
         r_mem_err  <= 1'b0;
      end else if (r_state == S_RUN) begin
         if (dmem_req && !dmem_ready) begin
            r_state    <= S_WAIT;
            r_wait_cnt <= WCW'(1);
         end
      end else if (r_state == S_WAIT) begin
         if (dmem_ready) begin
            r_state <= S_RUN;
         end else if (r_wait_cnt == TIMEOUT) begin
            r_state   <= S_ERR;
            r_mem_err <= 1'b1;
         end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
         end
      end
   end

   // Saturating count of cycles the decode stage was held
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_stall_cycles <= '0;
      else if (stall_d && r_stall_cycles != '1)
         r_stall_cycles <= r_stall_cycles + 1'b1;
   end

   assign mem_err      = r_mem_err;
   assign stall_cycles = r_stall_cycles;
endmodule

// File: tb/tb_pl_hazard_ctrl.sv
// tb_pl_hazard_ctrl: directed scoreboard bench for pl_hazard_ctrl
module tb_pl_hazard_ctrl;
   logic        clk, rst;
   logic [4:0]  id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
   logic        id_uses_rs1, id_uses_rs2, ex_regwrite, ex_pcsrc;
   logic [1:0]  ex_resultsrc;
   logic        mem_regwrite, wb_regwrite, dmem_req, dmem_ready;
   logic        stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w;
   logic [1:0]  fwd_a_e, fwd_b_e;
   logic        mem_err;
   logic [15:0] stall_cycles;

   typedef struct {
      string       name;
      logic [27:0] v;
   } exp_t;

   exp_t q[$];
   int   errors = 0;
   int   checks = 0;

   pl_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(16)) dut (
      .clk(clk), .rst(rst),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
      .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite),
      .ex_resultsrc(ex_resultsrc), .ex_pcsrc(ex_pcsrc),
      .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
      .dmem_req(dmem_req), .dmem_ready(dmem_ready),
      .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
      .flush_d(flush_d), .flush_e(flush_e), .flush_w(flush_w),
      .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e), .mem_err(mem_err), .stall_cycles(stall_cycles)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Monitor: every mid-cycle with a pending expectation, compare the whole output bundle
   always @(negedge clk) begin
      if (q.size() != 0) begin
         exp_t e;
         logic [27:0] act;
         e   = q.pop_front();
         act = {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w,
                fwd_a_e, fwd_b_e, mem_err, stall_cycles};
         checks++;
         if (act !== e.v) begin
            errors++;
            $display("FAIL %s: got st=%b fa=%b fb=%b err=%b cnt=%0d, expected st=%b fa=%b fb=%b err=%b cnt=%0d",
                     e.name, act[27:21], act[20:19], act[18:17], act[16], act[15:0],
                     e.v[27:21], e.v[20:19], e.v[18:17], e.v[16], e.v[15:0]);
         end
      end
   end

   task automatic idle();
      id_rs1 = 0; id_rs2 = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
      ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0; ex_regwrite = 0; ex_resultsrc = 2'b00; ex_pcsrc = 0;
      mem_rd = 0; mem_regwrite = 0; wb_rd = 0; wb_regwrite = 0;
      dmem_req = 0; dmem_ready = 0;
   endtask

   // st order: stall_f stall_d stall_e stall_m flush_d flush_e flush_w
   task automatic vec(input string n, input logic [6:0] st, input logic [1:0] fa,
                      input logic [1:0] fb, input logic me, input logic [15:0] sc);
      exp_t e;
      e.name = n;
      e.v    = {st, fa, fb, me, sc};
      q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic load_use(input logic [4:0] rd, input logic [4:0] r1, input logic u1,
                           input logic [4:0] r2, input logic u2);
      idle();
      ex_regwrite = 1; ex_resultsrc = 2'b01; ex_rd = rd;
      id_rs1 = r1; id_uses_rs1 = u1; id_rs2 = r2; id_uses_rs2 = u2;
   endtask

   initial begin
      rst = 1;
      idle();
      @(posedge clk);
      #1;
      vec("reset_idle", 7'b0000000, 2'b00, 2'b00, 0, 0);
      rst = 0;
      vec("idle_after_reset", 7'b0000000, 2'b00, 2'b00, 0, 0);
      load_use(5, 5, 1, 0, 0);
      vec("load_use_rs1", 7'b1100010, 2'b00, 2'b00, 0, 0);
      idle();
      vec("cnt_after_lu", 7'b0000000, 2'b00, 2'b00, 0, 1);
      load_use(0, 0, 1, 0, 0);
      vec("load_use_x0", 7'b0000000, 2'b00, 2'b00, 0, 1);
      load_use(9, 9, 0, 3, 1);
      vec("load_use_unused_rs1", 7'b0000000, 2'b00, 2'b00, 0, 1);
      load_use(9, 3, 1, 9, 1);
      vec("load_use_rs2", 7'b1100010, 2'b00, 2'b00, 0, 1);
      load_use(9, 9, 1, 0, 0);
      ex_resultsrc = 2'b00;
      vec("non_load_match", 7'b0000000, 2'b00, 2'b00, 0, 2);
      idle();
      ex_rs1 = 7; mem_rd = 7; wb_rd = 7; mem_regwrite = 1; wb_regwrite = 1;
      vec("fwd_mem_prio", 7'b0000000, 2'b10, 2'b00, 0, 2);
      mem_regwrite = 0;
      vec("fwd_wb", 7'b0000000, 2'b01, 2'b00, 0, 2);
      ex_rs1 = 0; mem_rd = 0; wb_rd = 0; mem_regwrite = 1;
      vec("fwd_x0", 7'b0000000, 2'b00, 2'b00, 0, 2);
      ex_rs1 = 4; ex_rs2 = 3; mem_rd = 4; wb_rd = 3;
      vec("fwd_mixed", 7'b0000000, 2'b10, 2'b01, 0, 2);
      idle();
      ex_pcsrc = 1;
      vec("branch", 7'b0000110, 2'b00, 2'b00, 0, 2);
      idle();
      vec("idle_after_branch", 7'b0000000, 2'b00, 2'b00, 0, 2);
      load_use(6, 6, 1, 0, 0);
      ex_pcsrc = 1;
      vec("branch_and_lu", 7'b1100110, 2'b00, 2'b00, 0, 2);
      idle();
      dmem_req = 1;
      vec("mem_wait_1", 7'b1111001, 2'b00, 2'b00, 0, 3);
      vec("mem_wait_2", 7'b1111001, 2'b00, 2'b00, 0, 4);
      vec("mem_wait_3", 7'b1111001, 2'b00, 2'b00, 0, 5);
      dmem_ready = 1;
      vec("mem_done", 7'b0000000, 2'b00, 2'b00, 0, 6);
      idle();
      vec("idle_after_mem", 7'b0000000, 2'b00, 2'b00, 0, 6);
      dmem_req = 1; ex_pcsrc = 1;
      vec("branch_wait_1", 7'b1111001, 2'b00, 2'b00, 0, 6);
      vec("branch_wait_2", 7'b1111001, 2'b00, 2'b00, 0, 7);
      dmem_ready = 1;
      vec("branch_released", 7'b0000110, 2'b00, 2'b00, 0, 8);
      idle();
      vec("idle_before_timeout", 7'b0000000, 2'b00, 2'b00, 0, 8);
      dmem_req = 1;
      for (int i = 0; i < 5; i++)
         vec($sformatf("timeout_wait_%0d", i), 7'b1111001, 2'b00, 2'b00, 0, 16'(8 + i));
      vec("timeout_err", 7'b1111001, 2'b00, 2'b00, 1, 13);
      dmem_req = 0; ex_pcsrc = 1;
      vec("error_sticky", 7'b1111001, 2'b00, 2'b00, 1, 14);
      idle();
      rst = 1;
      vec("reset_from_error", 7'b0000000, 2'b00, 2'b00, 0, 0);
      rst = 0;
      vec("run_after_reset", 7'b0000000, 2'b00, 2'b00, 0, 0);
      for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
      if (q.size() != 0) begin
         errors++;
         checks++;
         $display("FAIL drain: got %0d pending, expected 0", q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/pl_hazard_ctrl.md
Name: pl_hazard_ctrl

Overview:
Pipeline hazard and sequencing controller for the 5-stage RV32I core (F/D/E/M/W).
- Generates per-stage stall and flush strobes and EX-stage forwarding selects.
- Sequences multi-cycle data-memory accesses through a req/ready handshake with a timeout watchdog.
- Keeps a saturating stall-cycle counter.
- Sits beside the decode control unit; its stall_d output gates decode RegWrite.

Parameters:
MEM_TIMEOUT, 255, max consecutive wait cycles on one dmem access before error
CNT_W, 16, width of stall_cycles counter

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
id_rs1  in  5  D-stage source reg 1
id_rs2  in  5  D-stage source reg 2
id_uses_rs1  in  1  D instr reads rs1
id_uses_rs2  in  1  D instr reads rs2
ex_rs1  in  5  E-stage source reg 1
ex_rs2  in  5  E-stage source reg 2
ex_rd  in  5  E-stage dest reg
ex_regwrite  in  1  E instr writes rd
ex_resultsrc  in  2  E instr result source; 2'b01 = load
ex_pcsrc  in  1  taken branch/JAL/JALR resolved in E
mem_rd  in  5  M-stage dest reg
mem_regwrite  in  1  M instr writes rd
wb_rd  in  5  W-stage dest reg
wb_regwrite  in  1  W instr writes rd
dmem_req  in  1  M stage requests data-memory access
dmem_ready  in  1  memory completes access this cycle
stall_f  out  1  hold PC
stall_d  out  1  hold F/D register
stall_e  out  1  hold D/E register
stall_m  out  1  hold E/M register
flush_d  out  1  clear F/D register (bubble)
flush_e  out  1  clear D/E register (bubble)
flush_w  out  1  clear M/W register (bubble)
fwd_a_e  out  2  E operand A select: 00 regfile, 01 WB, 10 MEM
fwd_b_e  out  2  E operand B select, same encoding
mem_err  out  1  sticky dmem timeout flag
stall_cycles  out  CNT_W  cycles with stall_d=1, saturating

Behaviour:
- Reset (async, while rst=1): state=RUN, wait_cnt=0, mem_err=0, stall_cycles=0. All strobes are 0 for idle inputs.
- FSM states: RUN, MEM_WAIT, ERROR.
  - RUN→MEM_WAIT when dmem_req & !dmem_ready; wait_cnt←1.
  - MEM_WAIT→RUN when dmem_ready.
  - MEM_WAIT→ERROR when !dmem_ready & wait_cnt==MEM_TIMEOUT; mem_err←1.
  - MEM_WAIT otherwise: wait_cnt++.
  - ERROR is terminal until rst.
  - A zero-wait access (req & ready in the same cycle) never leaves RUN.
- mem_stall = (dmem_req & !dmem_ready) | (state==ERROR). Combinational, same cycle.
- lu_stall = ex_regwrite & ex_resultsrc==2'b01 & ex_rd!=0 & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
- Strobes:
  - stall_f = stall_d = lu_stall | mem_stall.
  - stall_e = stall_m = mem_stall.
  - flush_w = mem_stall.
  - flush_d = ex_pcsrc & !mem_stall.
  - flush_e = (lu_stall | ex_pcsrc) & !mem_stall.
- Priority:
  - mem_stall overrides all flushes. A branch resolved while memory is stalled is held in E and flushes on the first non-stalled cycle.
  - ex_pcsrc with lu_stall: flush_d=flush_e=1 and stall_f=stall_d=1. The F/D flush wins in the pipeline register (flush has priority over enable there).
- Forwarding (A shown; B identical with ex_rs2):
  - 10 if mem_regwrite & mem_rd!=0 & mem_rd==ex_rs1.
  - else 01 if wb_regwrite & wb_rd!=0 & wb_rd==ex_rs1.
  - else 00.
  - Never forward x0.
  - Forwarding is purely combinational and unaffected by stalls.
- stall_cycles increments on each clock with stall_d=1 and saturates at all-ones.
- Reset mid-wait: FSM returns to RUN immediately. mem_err and counters clear.
- Latency: all strobes are combinational from inputs and current state (0-cycle). FSM, counters and mem_err update on the rising edge.

Test Plan:
- Load-use: E = lw x5 (ex_resultsrc=01, ex_rd=5, ex_regwrite=1), D = add reading rs1=5 → one cycle with stall_f=stall_d=flush_e=1, stall_e=0; stall_cycles=1. Same stimulus with ex_rd=0 → no stall.
- Forward priority: ex_rs1=7, mem_rd=7, wb_rd=7, both regwrites=1 → fwd_a_e=10. Drop mem_regwrite → 01. Set rd=0 with writes enabled → 00.
- Taken branch: ex_pcsrc=1 for one cycle, no memory activity → flush_d=flush_e=1 that cycle, no stalls.
- Memory wait: dmem_req=1 with dmem_ready low for 3 cycles, then high → stall_f/d/e/m=flush_w=1 for exactly 3 cycles; state returns to RUN; stall_cycles=3; mem_err=0.
- Branch during wait: ex_pcsrc=1 throughout a 2-cycle wait → flush_d/e=0 during the wait, 1 on the cycle dmem_ready=1.
- Timeout with MEM_TIMEOUT=4: ready never asserted → mem_err=1 after the 4th wait cycle; all stalls remain 1; assert rst → mem_err=0, stalls=0, state RUN.
